// File: rtl/cmp_track_unit.sv
// Compare/min-max tracking unit: EQ/GT/LT/GE/LE predicates plus a running MIN/MAX tracker with a sample counter.
// Latency: one cycle from accept to registered CMP_OUT/CMP_Flag/OUT_VALID; the tracker updates on the same edge.
// Backpressure: IN_READY = !OUT_VALID || OUT_READY; the held result stays stable while OUT_READY is low.
module cmp_track_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALU_FUNC,
    input  logic                  SIGNED_CMP,
    input  logic                  CLR_TRACK,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [2:0]            CMP_OUT,
    output logic                  CMP_Flag,
    output logic [DATA_WIDTH-1:0] TRACK_OUT,
    output logic [CNT_WIDTH-1:0]  TRACK_CNT
);

    localparam logic [2:0] FN_NOP = 3'b000;
    localparam logic [2:0] FN_EQ  = 3'b001;
    localparam logic [2:0] FN_GT  = 3'b010;
    localparam logic [2:0] FN_LT  = 3'b011;
    localparam logic [2:0] FN_GE  = 3'b100;
    localparam logic [2:0] FN_LE  = 3'b101;
    localparam logic [2:0] FN_MIN = 3'b110;
    localparam logic [2:0] FN_MAX = 3'b111;

    typedef enum logic {
        TRK_EMPTY = 1'b0,
        TRK_ARMED = 1'b1
    } trk_state_t;

    trk_state_t            r_trk_state;
    logic [DATA_WIDTH-1:0] r_track;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [2:0]            r_cmp_out;
    logic                  r_cmp_flag;
    logic                  r_out_valid;

    logic                  w_accept;
    logic                  w_is_mm;
    logic                  w_a_eq_b;
    logic                  w_a_lt_b;
    logic                  w_a_gt_b;
    logic                  w_a_lt_t;
    logic                  w_a_gt_t;
    logic                  w_mm_update;
    logic                  w_mm_load;
    logic [2:0]            w_code;
    logic                  w_flag;

    assign IN_READY  = !r_out_valid || OUT_READY;
    assign w_accept  = IN_VALID && IN_READY;
    assign w_is_mm   = (ALU_FUNC == FN_MIN) || (ALU_FUNC == FN_MAX);

    // Operand comparisons against B and against the tracked value, honouring signedness
    assign w_a_eq_b  = (A == B);
    assign w_a_lt_b  = SIGNED_CMP ? ($signed(A) < $signed(B)) : (A < B);
    assign w_a_gt_b  = SIGNED_CMP ? ($signed(A) > $signed(B)) : (A > B);
    assign w_a_lt_t  = SIGNED_CMP ? ($signed(A) < $signed(r_track)) : (A < r_track);
    assign w_a_gt_t  = SIGNED_CMP ? ($signed(A) > $signed(r_track)) : (A > r_track);

    // A clear in the same cycle empties the tracker first, so the sample loads unconditionally
    assign w_mm_load   = CLR_TRACK || (r_trk_state == TRK_EMPTY);
    assign w_mm_update = (ALU_FUNC == FN_MAX) ? w_a_gt_t : w_a_lt_t;

    // Result code decode: the function code itself when the predicate or tracker update fires, else zero
    always_comb begin
        w_code = 3'b000;
        w_flag = 1'b1;
        case (ALU_FUNC)
            FN_NOP: w_flag = 1'b0;
            FN_EQ:  w_code = w_a_eq_b  ? FN_EQ : 3'b000;
            FN_GT:  w_code = w_a_gt_b  ? FN_GT : 3'b000;
            FN_LT:  w_code = w_a_lt_b  ? FN_LT : 3'b000;
            FN_GE:  w_code = !w_a_lt_b ? FN_GE : 3'b000;
            FN_LE:  w_code = !w_a_gt_b ? FN_LE : 3'b000;
            default: w_code = (w_mm_load || w_mm_update) ? ALU_FUNC : 3'b000;
        endcase
    end

    // Output result registers with valid/ready handshake
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cmp_out   <= 3'b000;
            r_cmp_flag  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_cmp_out   <= w_code;
            r_cmp_flag  <= w_flag;
            r_out_valid <= 1'b1;
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    // Tracker state machine: EMPTY/ARMED with shared min/max value and saturating sample count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_trk_state <= TRK_EMPTY;
            r_track     <= '0;
            r_cnt       <= '0;
        end else if (w_accept && w_is_mm) begin
            if (w_mm_load) begin
                r_trk_state <= TRK_ARMED;
                r_track     <= A;
                r_cnt       <= CNT_WIDTH'(1);
            end else begin
                if (w_mm_update) begin
                    r_track <= A;
                end
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end
        end else if (CLR_TRACK) begin
            r_trk_state <= TRK_EMPTY;
            r_track     <= '0;
            r_cnt       <= '0;
        end
    end

    assign OUT_VALID = r_out_valid;
    assign CMP_OUT   = r_cmp_out;
    assign CMP_Flag  = r_cmp_flag;
    assign TRACK_OUT = r_track;
    assign TRACK_CNT = r_cnt;

endmodule

// File: tb/tb_cmp_track_unit.sv
// Bench for cmp_track_unit: directed steps with a result scoreboard.
// Main instance uses default widths; a second instance with a 2-bit counter covers saturation.
// Expected codes are hand-derived per step and queued at accept time.
module tb_cmp_track_unit;

    logic        CLK;
    logic        RST;
    logic [15:0] A, B;
    logic [2:0]  ALU_FUNC;
    logic        SIGNED_CMP, CLR_TRACK, IN_VALID, OUT_READY;
    logic        IN_READY, OUT_VALID, CMP_Flag;
    logic [2:0]  CMP_OUT;
    logic [15:0] TRACK_OUT;
    logic [7:0]  TRACK_CNT;

    logic [15:0] s_a, s_b;
    logic [2:0]  s_func;
    logic        s_sgn, s_clr, s_in_valid, s_out_ready;
    logic        s_in_ready, s_out_valid, s_flag;
    logic [2:0]  s_cmp_out;
    logic [15:0] s_track;
    logic [1:0]  s_cnt;

    int errors = 0;
    int checks = 0;
    logic [3:0] sb_q[$];

    cmp_track_unit #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
        .SIGNED_CMP(SIGNED_CMP), .CLR_TRACK(CLR_TRACK), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag), .TRACK_OUT(TRACK_OUT), .TRACK_CNT(TRACK_CNT)
    );

    cmp_track_unit #(.DATA_WIDTH(16), .CNT_WIDTH(2)) dut_sat (
        .CLK(CLK), .RST(RST), .A(s_a), .B(s_b), .ALU_FUNC(s_func),
        .SIGNED_CMP(s_sgn), .CLR_TRACK(s_clr), .IN_VALID(s_in_valid),
        .IN_READY(s_in_ready), .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready),
        .CMP_OUT(s_cmp_out), .CMP_Flag(s_flag), .TRACK_OUT(s_track), .TRACK_CNT(s_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every consumed result must match the oldest queued expectation
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed code=%0b flag=%0b expected no result", CMP_OUT, CMP_Flag);
            end else begin
                logic [3:0] e;
                e = sb_q.pop_front();
                checks++;
                assert ({CMP_OUT, CMP_Flag} === e) else begin
                    errors++;
                    $error("FAIL sb_result: observed code=%0b flag=%0b expected code=%0b flag=%0b",
                           CMP_OUT, CMP_Flag, e[3:1], e[0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drive one operation until accepted (bounded), queueing its expected result when push is set
    task automatic send(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic sg, input logic clr, input logic [2:0] ec, input logic ef,
                        input logic push);
        int n;
        n = 0;
        ALU_FUNC = f; A = a; B = b; SIGNED_CMP = sg; CLR_TRACK = clr; IN_VALID = 1'b1;
        @(negedge CLK);
        while (!IN_READY && n < 20) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        assert (IN_READY === 1'b1) else begin
            errors++;
            $error("FAIL accept_timeout: observed IN_READY=%b expected 1", IN_READY);
        end
        if (IN_READY === 1'b1 && push) sb_q.push_back({ec, ef});
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        CLR_TRACK = 1'b0;
    endtask

    initial begin
        RST = 1'b1; A = '0; B = '0; ALU_FUNC = 3'b000; SIGNED_CMP = 1'b0;
        CLR_TRACK = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        s_a = '0; s_b = '0; s_func = 3'b111; s_sgn = 1'b0; s_clr = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b1;

        // Reset state
        idle(2);
        chk("rst_cmp_out", 32'(CMP_OUT), 32'h0);
        chk("rst_flag", 32'(CMP_Flag), 32'h0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'h0);
        chk("rst_track", 32'(TRACK_OUT), 32'h0);
        chk("rst_cnt", 32'(TRACK_CNT), 32'h0);
        chk("rst_in_ready", 32'(IN_READY), 32'h1);
        RST = 1'b0;

        // Compare operations, signed versus unsigned
        send(3'b011, 16'h8000, 16'h0001, 1'b1, 1'b0, 3'b011, 1'b1, 1'b1);
        send(3'b011, 16'h8000, 16'h0001, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        send(3'b100, 16'h1234, 16'h1234, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);
        send(3'b001, 16'h0005, 16'h0006, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        send(3'b010, 16'h0007, 16'hFFFD, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
        send(3'b010, 16'h0007, 16'hFFFD, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        send(3'b101, 16'h0003, 16'h0003, 1'b0, 1'b0, 3'b101, 1'b1, 1'b1);
        send(3'b000, 16'h0009, 16'h0001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
        chk("nop_track", 32'(TRACK_OUT), 32'h0);
        chk("nop_cnt", 32'(TRACK_CNT), 32'h0);

        // Signed MIN stream 5, -3, 7, -3
        send(3'b110, 16'h0005, 16'h0000, 1'b1, 1'b0, 3'b110, 1'b1, 1'b1);
        chk("min1_track", 32'(TRACK_OUT), 32'h0005);
        send(3'b110, 16'hFFFD, 16'h0000, 1'b1, 1'b0, 3'b110, 1'b1, 1'b1);
        chk("min2_track", 32'(TRACK_OUT), 32'hFFFD);
        send(3'b110, 16'h0007, 16'h0000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
        send(3'b110, 16'hFFFD, 16'h0000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
        chk("min4_track", 32'(TRACK_OUT), 32'hFFFD);
        chk("min4_cnt", 32'(TRACK_CNT), 32'd4);

        // Backpressure: result held stable for three stalled cycles
        idle(2);
        OUT_READY = 1'b0;
        send(3'b001, 16'h0055, 16'h0055, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_out_valid", 32'(OUT_VALID), 32'h1);
            chk("stall_cmp_out", 32'(CMP_OUT), 32'h1);
            chk("stall_in_ready", 32'(IN_READY), 32'h0);
            idle(1);
        end
        OUT_READY = 1'b1;
        #1;
        chk("release_in_ready", 32'(IN_READY), 32'h1);
        idle(2);

        // Tracker clear, MAX, clear-with-sample, mixed MIN/MAX, equality, unsigned/signed tracking
        CLR_TRACK = 1'b1;
        idle(1);
        CLR_TRACK = 1'b0;
        chk("clr_track", 32'(TRACK_OUT), 32'h0);
        chk("clr_cnt", 32'(TRACK_CNT), 32'h0);
        send(3'b111, 16'd20, 16'h0000, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1);
        send(3'b111, 16'd15, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        chk("max_hold_track", 32'(TRACK_OUT), 32'd20);
        chk("max_hold_cnt", 32'(TRACK_CNT), 32'd2);
        send(3'b111, 16'd9, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1);
        chk("clrmax_track", 32'(TRACK_OUT), 32'd9);
        chk("clrmax_cnt", 32'(TRACK_CNT), 32'd1);
        send(3'b110, 16'd4, 16'h0000, 1'b0, 1'b0, 3'b110, 1'b1, 1'b1);
        send(3'b111, 16'd4, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        chk("mix_track", 32'(TRACK_OUT), 32'd4);
        chk("mix_cnt", 32'(TRACK_CNT), 32'd3);
        send(3'b111, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1);
        send(3'b110, 16'h8000, 16'h0000, 1'b1, 1'b0, 3'b110, 1'b1, 1'b1);
        chk("smin_track", 32'(TRACK_OUT), 32'h8000);
        chk("smin_cnt", 32'(TRACK_CNT), 32'd5);

        // Reset during a stall discards the pending result
        idle(2);
        OUT_READY = 1'b0;
        send(3'b010, 16'h0009, 16'h0001, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0);
        chk("pre_rst_valid", 32'(OUT_VALID), 32'h1);
        chk("pre_rst_code", 32'(CMP_OUT), 32'h2);
        RST = 1'b1;
        #1;
        chk("async_rst_valid", 32'(OUT_VALID), 32'h0);
        chk("async_rst_code", 32'(CMP_OUT), 32'h0);
        chk("async_rst_flag", 32'(CMP_Flag), 32'h0);
        chk("async_rst_track", 32'(TRACK_OUT), 32'h0);
        chk("async_rst_cnt", 32'(TRACK_CNT), 32'h0);
        chk("async_rst_in_ready", 32'(IN_READY), 32'h1);
        idle(1);
        RST = 1'b0;
        OUT_READY = 1'b1;
        idle(3);
        chk("post_rst_valid", 32'(OUT_VALID), 32'h0);
        send(3'b001, 16'h0001, 16'h0001, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1);
        send(3'b110, 16'h0003, 16'h0000, 1'b0, 1'b0, 3'b110, 1'b1, 1'b1);
        chk("post_rst_track", 32'(TRACK_OUT), 32'h3);
        chk("post_rst_cnt", 32'(TRACK_CNT), 32'h1);

        // Counter saturation on the 2-bit instance: six MAX accepts
        for (int i = 1; i <= 6; i++) begin
            s_a = 16'(i);
            s_in_valid = 1'b1;
            chk("sat_in_ready", 32'(s_in_ready), 32'h1);
            idle(1);
            chk("sat_cnt", 32'(s_cnt), (i < 3) ? 32'(i) : 32'd3);
            chk("sat_code", 32'(s_cmp_out), 32'h7);
            chk("sat_flag", 32'(s_flag), 32'h1);
            chk("sat_valid", 32'(s_out_valid), 32'h1);
        end
        s_in_valid = 1'b0;
        chk("sat_track", 32'(s_track), 32'd6);

        // Every expected result must have been consumed
        idle(3);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
